// File: rtl/switchbox_cfg_loader_if.sv
// Configuration bitstream and committed-selector bus between the fabric
// config port and one switch-matrix loader.
interface switchbox_cfg_loader_if #(
   parameter int NTOP  = 5,
   parameter int NSIDE = 4,
   parameter int SELW  = 6
);
   localparam int NENT = 2 * NTOP + 2 * NSIDE;

   logic                   cfg_din;
   logic                   cfg_valid;
   logic                   cfg_abort;
   logic [NENT*SELW-1:0]   route_cfg;
   logic                   cfg_busy;
   logic                   cfg_done;
   logic                   cfg_err;

   modport master (
      output cfg_din, cfg_valid, cfg_abort,
      input  route_cfg, cfg_busy, cfg_done, cfg_err
   );

   modport slave (
      input  cfg_din, cfg_valid, cfg_abort,
      output route_cfg, cfg_busy, cfg_done, cfg_err
   );
endinterface

// File: rtl/switchbox_cfg_loader.sv
// Serial loader: hunts for the sync byte, shifts selectors into a shadow, range-checks
// and commits them atomically. Define CFG_CHK_EN to add the trailing XOR checksum.
module switchbox_cfg_loader #(
   parameter int         NTOP  = 5,
   parameter int         NSIDE = 4,
   parameter int         SELW  = 6,
   parameter logic [7:0] SYNC  = 8'hA5
) (
   input  logic                 clk,
   input  logic                 rst,
   switchbox_cfg_loader_if.slave cfg
);
   localparam int NENT = 2 * NTOP + 2 * NSIDE;
   localparam int W    = NENT * SELW;
   localparam int CW   = $clog2(W);
   localparam int SW   = $clog2(SELW);

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      LOAD   = 2'd1,
      COMMIT = 2'd2
`ifdef CFG_CHK_EN
      , CHECK = 2'd3
`endif
   } state_t;

   state_t          state_r, state_s;
   logic [7:0]      sync_r, sync_s;
   logic [CW-1:0]   bit_cnt_r, bit_cnt_s;
   logic [SW-1:0]   sub_cnt_r, sub_cnt_s;
   logic [SELW-1:0] ent_r, ent_s, ent_nxt_s;
   logic [W-1:0]    shadow_r, shadow_s;
   logic [W-1:0]    route_r, route_s;
   logic            busy_r, busy_s;
   logic            done_r, done_s;
   logic            err_r, err_s;
   logic            ok_s;
`ifdef CFG_CHK_EN
   logic [SELW-1:0] chk_r, chk_s;
`endif

   function automatic logic entry_ok(input logic [SELW-1:0] e);
      logic [SELW-4:0] idx;
      idx = e[SELW-1:3];
      case (e[2:0])
         3'd0:       entry_ok = 1'b1;
         3'd1, 3'd3: entry_ok = (int'(idx) < NTOP);
         3'd2, 3'd4: entry_ok = (int'(idx) < NSIDE);
         default:    entry_ok = 1'b0;
      endcase
   endfunction

   function automatic logic frame_ok(input logic [W-1:0] s);
      frame_ok = 1'b1;
      for (int e = 0; e < NENT; e++) begin
         frame_ok = frame_ok & entry_ok(s[SELW*e +: SELW]);
      end
   endfunction

`ifdef CFG_CHK_EN
   function automatic logic [SELW-1:0] xor_sum(input logic [W-1:0] s);
      xor_sum = {SELW{1'b0}};
      for (int e = 0; e < NENT; e++) begin
         xor_sum = xor_sum ^ s[SELW*e +: SELW];
      end
   endfunction
`endif

   // Next-state, datapath and registered-output next values
   always_comb begin
      state_s   = state_r;
      sync_s    = sync_r;
      bit_cnt_s = bit_cnt_r;
      sub_cnt_s = sub_cnt_r;
      ent_s     = ent_r;
      shadow_s  = shadow_r;
      route_s   = route_r;
      done_s    = 1'b0;
      err_s     = 1'b0;
      ok_s      = 1'b0;
      ent_nxt_s = {ent_r[SELW-2:0], cfg.cfg_din};
`ifdef CFG_CHK_EN
      chk_s     = chk_r;
`endif
      case (state_r)
         HUNT: begin
            if (cfg.cfg_abort) begin
               sync_s = 8'h00;
            end else if (cfg.cfg_valid) begin
               if ({sync_r[6:0], cfg.cfg_din} == SYNC) begin
                  state_s   = LOAD;
                  sync_s    = 8'h00;
                  bit_cnt_s = {CW{1'b0}};
                  sub_cnt_s = {SW{1'b0}};
               end else begin
                  sync_s = {sync_r[6:0], cfg.cfg_din};
               end
            end else begin
               sync_s = sync_r;
            end
         end
         LOAD: begin
            if (cfg.cfg_abort) begin
               state_s = HUNT;
            end else if (cfg.cfg_valid) begin
               ent_s     = ent_nxt_s;
               bit_cnt_s = bit_cnt_r + CW'(1);
               // Completed entries enter at the top so entry 0 ends up lowest
               if (sub_cnt_r == SW'(SELW - 1)) begin
                  shadow_s  = {ent_nxt_s, shadow_r[W-1:SELW]};
                  sub_cnt_s = {SW{1'b0}};
               end else begin
                  sub_cnt_s = sub_cnt_r + SW'(1);
               end
               if (bit_cnt_r == CW'(W - 1)) begin
                  bit_cnt_s = {CW{1'b0}};
`ifdef CFG_CHK_EN
                  state_s   = CHECK;
`else
                  state_s   = COMMIT;
`endif
               end else begin
                  state_s = LOAD;
               end
            end else begin
               state_s = LOAD;
            end
         end
`ifdef CFG_CHK_EN
         CHECK: begin
            if (cfg.cfg_abort) begin
               state_s = HUNT;
            end else if (cfg.cfg_valid) begin
               chk_s     = {chk_r[SELW-2:0], cfg.cfg_din};
               bit_cnt_s = bit_cnt_r + CW'(1);
               if (bit_cnt_r == CW'(SELW - 1)) begin
                  state_s = COMMIT;
               end else begin
                  state_s = CHECK;
               end
            end else begin
               state_s = CHECK;
            end
         end
`endif
         COMMIT: begin
`ifdef CFG_CHK_EN
            ok_s = frame_ok(shadow_r) && (chk_r == xor_sum(shadow_r));
`else
            ok_s = frame_ok(shadow_r);
`endif
            if (ok_s) begin
               route_s = shadow_r;
               done_s  = 1'b1;
            end else begin
               err_s   = 1'b1;
            end
            state_s = HUNT;
            // A bit arriving during commit is already the first hunt bit
            sync_s  = cfg.cfg_valid ? {7'b0000000, cfg.cfg_din} : 8'h00;
         end
         default: begin
            state_s = HUNT;
            sync_s  = 8'h00;
         end
      endcase
      busy_s = (state_s != HUNT);
   end

   // State and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r   <= HUNT;
         sync_r    <= 8'h00;
         bit_cnt_r <= {CW{1'b0}};
         sub_cnt_r <= {SW{1'b0}};
         ent_r     <= {SELW{1'b0}};
         shadow_r  <= {W{1'b0}};
         route_r   <= {W{1'b0}};
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
         err_r     <= 1'b0;
`ifdef CFG_CHK_EN
         chk_r     <= {SELW{1'b0}};
`endif
      end else begin
         state_r   <= state_s;
         sync_r    <= sync_s;
         bit_cnt_r <= bit_cnt_s;
         sub_cnt_r <= sub_cnt_s;
         ent_r     <= ent_s;
         shadow_r  <= shadow_s;
         route_r   <= route_s;
         busy_r    <= busy_s;
         done_r    <= done_s;
         err_r     <= err_s;
`ifdef CFG_CHK_EN
         chk_r     <= chk_s;
`endif
      end
   end

   assign cfg.route_cfg = route_r;
   assign cfg.cfg_busy  = busy_r;
   assign cfg.cfg_done  = done_r;
   assign cfg.cfg_err   = err_r;
endmodule

// File: tb/tb_switchbox_cfg_loader.sv
// Scoreboard bench for switchbox_cfg_loader: directed frames push expected commits,
// a negedge monitor checks each cfg_done/cfg_err pulse, its cycle and route_cfg.
module tb_switchbox_cfg_loader;
   localparam int NTOP  = 5;
   localparam int NSIDE = 4;
   localparam int SELW  = 6;
   localparam int NENT  = 18;
   localparam int W     = 108;

   typedef struct {
      logic         ok;
      logic [W-1:0] route;
      int           cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   vectors = 0;
   int   miscompares = 0;
   int   cyc = 0;
   exp_t q[$];
   logic [W-1:0] exp_route;
   logic [W-1:0] p_09, p_dist, p_0b, p_bad;

   switchbox_cfg_loader_if #(.NTOP(NTOP), .NSIDE(NSIDE), .SELW(SELW)) bus ();

   switchbox_cfg_loader #(.NTOP(NTOP), .NSIDE(NSIDE), .SELW(SELW), .SYNC(8'hA5)) dut (
      .clk (clk),
      .rst (rst),
      .cfg (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   // Monitor: every commit pulse must match the head of the scoreboard
   always @(negedge clk) begin
      exp_t e;
      if (rst === 1'b0 && (bus.cfg_done === 1'b1 || bus.cfg_err === 1'b1)) begin
         if (q.size() == 0) begin
            check("unexpected_pulse", W'({bus.cfg_done, bus.cfg_err}), W'(0));
         end else begin
            e = q.pop_front();
            check("pulse_kind", W'({bus.cfg_done, bus.cfg_err}), e.ok ? W'(2) : W'(1));
            check("pulse_cycle", W'(cyc), W'(e.cyc));
            check("route_cfg", bus.route_cfg, e.route);
         end
      end
   end

   function automatic logic [5:0] xor_sum(input logic [W-1:0] p);
      logic [5:0] x = 6'h00;
      for (int e = 0; e < NENT; e++) x = x ^ p[6*e +: 6];
      return x;
   endfunction

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         bus.cfg_valid = 1'b0;
         bus.cfg_abort = 1'b0;
         @(posedge clk); #1;
      end
   endtask

   task automatic send_bit(input logic b, input bit gaps);
      if (gaps && $urandom_range(0, 3) == 0) idle(1);
      bus.cfg_din   = b;
      bus.cfg_valid = 1'b1;
      bus.cfg_abort = 1'b0;
      @(posedge clk); #1;
      bus.cfg_valid = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] v, input bit gaps);
      for (int i = 7; i >= 0; i--) send_bit(v[i], gaps);
   endtask

   task automatic send_payload(input logic [W-1:0] p, input int nbits, input bit gaps);
      int n = 0;
      for (int e = 0; e < NENT; e++)
         for (int b = 5; b >= 0; b--)
            if (n < nbits) begin
               send_bit(p[6*e+b], gaps);
               n++;
            end
   endtask

   task automatic send_frame(input logic [W-1:0] p, input logic [5:0] chk,
                             input bit gaps, input bit ok);
      exp_t e;
      send_byte(8'hA5, gaps);
      check("busy_after_sync", W'(bus.cfg_busy), W'(1));
      send_payload(p, W, gaps);
`ifdef CFG_CHK_EN
      for (int b = 5; b >= 0; b--) send_bit(chk[b], gaps);
`endif
      if (ok) exp_route = p;
      e.ok = ok;
      e.route = exp_route;
      e.cyc = cyc + 1;
      q.push_back(e);
   endtask

   initial begin
      rst = 1'b1;
      bus.cfg_din = 1'b0;
      bus.cfg_valid = 1'b0;
      bus.cfg_abort = 1'b0;
      exp_route = '0;
      for (int e = 0; e < NENT; e++) begin
         p_09[6*e +: 6] = 6'h09;
         p_0b[6*e +: 6] = 6'h0B;
         if (e < 5)       p_dist[6*e +: 6] = {3'(e), 3'd1};
         else if (e < 10) p_dist[6*e +: 6] = {3'(e - 5), 3'd3};
         else if (e < 14) p_dist[6*e +: 6] = {3'(e - 10), 3'd4};
         else             p_dist[6*e +: 6] = {3'(e - 14), 3'd2};
      end

      #12;
      check("reset_route", bus.route_cfg, '0);
      check("reset_busy", W'(bus.cfg_busy), W'(0));
      check("reset_done_err", W'({bus.cfg_done, bus.cfg_err}), W'(0));
      @(posedge clk); #1;
      rst = 1'b0;
      idle(2);

      send_frame(p_09, 6'h00, 1'b0, 1'b1);
      idle(3);
      check("busy_idle", W'(bus.cfg_busy), W'(0));
      send_frame(p_dist, xor_sum(p_dist), 1'b0, 1'b1);
      idle(3);
`ifdef CFG_CHK_EN
      send_frame(p_09, 6'h01, 1'b0, 1'b0);
      idle(3);
`endif
      p_bad = p_09;
      p_bad[23:18] = 6'h05;
      send_frame(p_bad, xor_sum(p_bad), 1'b0, 1'b0);
      idle(3);
      p_bad = p_09;
      p_bad[65:60] = 6'h22;
      send_frame(p_bad, xor_sum(p_bad), 1'b0, 1'b0);
      idle(3);

      // Abort together with a valid bit after 50 payload bits
      send_byte(8'hA5, 1'b1);
      send_payload(p_0b, 50, 1'b1);
      bus.cfg_din = 1'b1;
      bus.cfg_valid = 1'b1;
      bus.cfg_abort = 1'b1;
      @(posedge clk); #1;
      bus.cfg_valid = 1'b0;
      bus.cfg_abort = 1'b0;
      check("busy_after_abort", W'(bus.cfg_busy), W'(0));
      check("route_after_abort", bus.route_cfg, exp_route);
      idle(2);
      send_frame(p_0b, xor_sum(p_0b), 1'b1, 1'b1);
      idle(3);

      // Stray 5A, then two frames back to back
      send_byte(8'h5A, 1'b0);
      send_frame(p_dist, xor_sum(p_dist), 1'b0, 1'b1);
      send_frame(p_09, 6'h00, 1'b0, 1'b1);
      idle(3);

      // Reset in the middle of LOAD
      send_byte(8'hA5, 1'b0);
      send_payload(p_dist, 30, 1'b0);
      rst = 1'b1;
      #1;
      check("midreset_route", bus.route_cfg, '0);
      check("midreset_busy", W'(bus.cfg_busy), W'(0));
      check("midreset_done_err", W'({bus.cfg_done, bus.cfg_err}), W'(0));
      exp_route = '0;
      @(posedge clk); #1;
      rst = 1'b0;
      idle(2);
      send_frame(p_dist, xor_sum(p_dist), 1'b0, 1'b1);

      idle(6);
      check("scoreboard_drained", W'(q.size()), W'(0));
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
